pipe_skid_buffer: RTL
=====================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 Parameter: WIDTH, 64, payload width in bits (legal range 1..256).
REQ-002 Parameter: BUBBLE, {WIDTH{1'b0}}, value driven on Out when no valid entry (pipeline NOP).
REQ-003 Port: Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: Rst  input  1  reset, synchronous and active-high.
REQ-005 Port: In  input  WIDTH  upstream payload.
REQ-006 Port: InValid  input  1  upstream payload valid.
REQ-007 Port: InReady  output  1  buffer can accept this cycle.
REQ-008 Port: Out  output  WIDTH  downstream payload.
REQ-009 Port: OutValid  output  1  Out holds a valid entry.
REQ-010 Port: OutReady  input  1  downstream consumes this cycle (stall when low).
REQ-011 Port: Flush  input  1  discard all held entries (branch/interrupt squash).
REQ-012 Port: Count  output  2  number of held entries, 0..2.

Function
REQ-013 Two storage entries: main (drives Out) and skid; states EMPTY (Count 0), ONE (1), FULL (2).
REQ-014 Accept = InValid & InReady; Consume = OutValid & OutReady; both evaluated in the same cycle.
REQ-015 InReady shall be a registered signal: 1 in EMPTY and ONE, 0 in FULL; no combinational path from OutReady to InReady.
REQ-016 Out and OutValid shall be driven directly from registers; no combinational path from In to Out.
REQ-017 Latency: payload accepted in cycle N appears on Out in cycle N+1 when the buffer was EMPTY or its main entry is consumed in cycle N.
REQ-018 EMPTY: Accept -> ONE, main <= In.
REQ-019 ONE: Accept & Consume -> ONE, main <= In; Accept & !Consume -> FULL, skid <= In; !Accept & Consume -> EMPTY; neither -> hold.
REQ-020 FULL: Consume -> ONE, main <= skid; !Consume -> hold; In ignored (InReady 0).
REQ-021 Ordering shall be strict FIFO; no payload is dropped or duplicated except by Flush or Rst.
REQ-022 Flush high at an edge: next state EMPTY, Count 0, OutValid 0, Out = BUBBLE, InReady 1; any simultaneous Accept is discarded; any simultaneous Consume is still a valid transfer for that cycle.
REQ-023 Whenever OutValid is 0, Out shall equal BUBBLE exactly; stale data shall never appear on Out.
REQ-024 While OutReady stays low in FULL, Out, OutValid and Count shall be stable across cycles.
REQ-025 Count shall equal the number of held valid entries every cycle and never exceed 2.

Reset
REQ-026 Rst high at an edge: state EMPTY, Count 0, OutValid 0, Out = BUBBLE, InReady 1 from the next cycle.
REQ-027 Rst overrides Flush, InValid and OutReady; entries in flight when Rst asserts are discarded.
REQ-028 Storage contents beyond main/skid validity need no reset; observable outputs shall still satisfy REQ-023.

Verification
REQ-029 Streaming: WIDTH 16, OutReady 1, InValid 1 with In = 0x0001,0x0002,0x0003 on consecutive cycles -> Out 0x0001,0x0002,0x0003 one cycle later each, Count 1 throughout, InReady 1.
REQ-030 Stall fill: OutReady 0, push 0x00AA then 0x00BB -> Count 2, InReady 0, Out 0x00AA held; third push 0x00CC ignored; OutReady 1 -> 0x00AA, 0x00BB, then OutValid 0, Out = BUBBLE.
REQ-031 Simultaneous in FULL: Count 2, OutReady 1, InValid 1 with 0x00CC -> 0x00CC not accepted (InReady 0); next cycle Count 1, Out 0x00BB, InReady 1.
REQ-032 Flush: Count 2, Flush 1 with InValid 1 In 0x1234 -> next cycle Count 0, OutValid 0, Out = BUBBLE (BUBBLE set to 0xFFFF in this test), 0x1234 never appears.
REQ-033 Reset mid-operation: Count 2, Rst 1 for one cycle with OutReady 1 and InValid 1 -> next cycle Count 0, OutValid 0, InReady 1, Out = BUBBLE; next push appears after 1 cycle.
REQ-034 Random: 10,000 cycles random InValid/OutReady/Flush (5%) -> scoreboard matches FIFO order, Count matches model, REQ-016/023 hold every cycle.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry registered skid buffer with flush and bubble insertion
module pipe_skid_buffer #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  input  logic             OutReady,
  input  logic             Flush,
  output logic [1:0]       Count
);
  logic [WIDTH-1:0] r_main, r_skid;
  logic [1:0]       r_count;
  logic             r_valid, r_ready;
  logic             w_accept, w_consume;
  assign w_accept  = InValid & r_ready;
  assign w_consume = r_valid & OutReady;
  // r_main is reloaded with BUBBLE whenever it empties, so Out needs no output mux
  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      r_main  <= BUBBLE;
      r_count <= 2'd0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_count)
        2'd0: if (w_accept) begin
          r_main  <= In;
          r_count <= 2'd1;
          r_valid <= 1'b1;
        end
        2'd1: if (w_accept && w_consume) begin
          r_main <= In;
        end else if (w_accept) begin
          r_skid  <= In;
          r_count <= 2'd2;
          r_ready <= 1'b0;
        end else if (w_consume) begin
          r_main  <= BUBBLE;
          r_count <= 2'd0;
          r_valid <= 1'b0;
        end
        2'd2: if (w_consume) begin
          r_main  <= r_skid;
          r_count <= 2'd1;
          r_ready <= 1'b1;
        end
        default: begin
          r_main  <= BUBBLE;
          r_count <= 2'd0;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
  assign Out      = r_main;
  assign OutValid = r_valid;
  assign InReady  = r_ready;
  assign Count    = r_count;
endmodule
